// File: rtl/output_interface.sv
// Result output buffer: first-word-fall-through FIFO tagging each result with a
// sequence number, with backpressure, drop reporting and a saturating drop counter.
module output_interface #(
    parameter int DATA_WIDTH     = 32,
    parameter int OUT_FIFO_DEPTH = 4,
    parameter int SEQ_WIDTH      = 8,
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      op_done,
    input  logic [DATA_WIDTH-1:0]     final_value,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic [SEQ_WIDTH-1:0]      out_seq,
    output logic                      res_full,
    output logic                      res_dropd,
    output logic [DROP_CNT_WIDTH-1:0] drop_cnt
);

    localparam int PTR_W = (OUT_FIFO_DEPTH > 1) ? $clog2(OUT_FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(OUT_FIFO_DEPTH);

    function automatic logic [DROP_CNT_WIDTH-1:0] sat_inc(input logic [DROP_CNT_WIDTH-1:0] val);
        logic [DROP_CNT_WIDTH-1:0] res;
        if (val == {DROP_CNT_WIDTH{1'b1}}) begin
            res = val;
        end else begin
            res = val + {{(DROP_CNT_WIDTH-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

    logic [DATA_WIDTH-1:0]     mem_data_r [OUT_FIFO_DEPTH];
    logic [SEQ_WIDTH-1:0]      mem_seq_r  [OUT_FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr_r;
    logic [PTR_W-1:0]          rd_ptr_r;
    logic [CNT_W-1:0]          count_r;
    logic [SEQ_WIDTH-1:0]      seq_r;
    logic                      out_valid_r;
    logic [DATA_WIDTH-1:0]     out_data_r;
    logic [SEQ_WIDTH-1:0]      out_seq_r;
    logic                      res_full_r;
    logic                      res_dropd_r;
    logic [DROP_CNT_WIDTH-1:0] drop_cnt_r;

    logic                      pop_s;
    logic                      push_s;
    logic                      drop_s;
    logic                      full_s;
    logic [CNT_W-1:0]          count_next_s;
    logic [PTR_W-1:0]          rd_next_s;
    logic [DATA_WIDTH-1:0]     head_data_s;
    logic [SEQ_WIDTH-1:0]      head_seq_s;

    // Handshake decode, next count and the head entry visible after this edge.
    always_comb begin
        pop_s        = out_valid_r & out_ready;
        full_s       = (count_r == DEPTH_C);
        push_s       = op_done & (~full_s | pop_s);
        drop_s       = op_done & full_s & ~pop_s;
        count_next_s = count_r;
        if (push_s && !pop_s) begin
            count_next_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (pop_s && !push_s) begin
            count_next_s = count_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_next_s = count_r;
        end
        if (pop_s) begin
            rd_next_s = rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
            rd_next_s = rd_ptr_r;
        end
        // A write landing on the next head slot bypasses the storage array.
        if (push_s && (wr_ptr_r == rd_next_s)) begin
            head_data_s = final_value;
            head_seq_s  = seq_r;
        end else begin
            head_data_s = mem_data_r[rd_next_s];
            head_seq_s  = mem_seq_r[rd_next_s];
        end
    end

    // Entry storage; contents need no reset since validity comes from count_r.
    always_ff @(posedge clk) begin
        if (rst_n && push_s) begin
            mem_data_r[wr_ptr_r] <= final_value;
            mem_seq_r[wr_ptr_r]  <= seq_r;
        end
    end

    // Pointers, occupancy, sequence tag and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            seq_r       <= {SEQ_WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            out_data_r  <= {DATA_WIDTH{1'b0}};
            out_seq_r   <= {SEQ_WIDTH{1'b0}};
            res_full_r  <= 1'b0;
            res_dropd_r <= 1'b0;
            drop_cnt_r  <= {DROP_CNT_WIDTH{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
                seq_r    <= seq_r + {{(SEQ_WIDTH-1){1'b0}}, 1'b1};
            end
            rd_ptr_r    <= rd_next_s;
            count_r     <= count_next_s;
            out_valid_r <= (count_next_s != {CNT_W{1'b0}});
            res_full_r  <= (count_next_s == DEPTH_C);
            res_dropd_r <= drop_s;
            if (drop_s) begin
                drop_cnt_r <= sat_inc(drop_cnt_r);
            end
            // Head only moves on pop or on fill from empty, so it holds under stall.
            if (count_next_s != {CNT_W{1'b0}}) begin
                out_data_r <= head_data_s;
                out_seq_r  <= head_seq_s;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_seq   = out_seq_r;
    assign res_full  = res_full_r;
    assign res_dropd = res_dropd_r;
    assign drop_cnt  = drop_cnt_r;

endmodule

// File: tb/tb_output_interface.sv
// Scoreboard bench for output_interface: a queue-based reference model predicts
// every emitted {data, seq}, the occupancy-derived flags and the drop counter.
module tb_output_interface;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_done;
    logic [31:0] final_value;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [7:0]  out_seq;
    logic        res_full;
    logic        res_dropd;
    logic [15:0] drop_cnt;

    int checks   = 0;
    int failures = 0;

    logic [39:0] exp_q[$];
    int          mcount  = 0;
    int          seq_m   = 0;
    int          drops_m = 0;
    bit          dropd_m = 1'b0;
    bit          started = 1'b0;

    always #5 clk = ~clk;

    output_interface #(
        .DATA_WIDTH(32), .OUT_FIFO_DEPTH(DEPTH), .SEQ_WIDTH(8), .DROP_CNT_WIDTH(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .op_done(op_done), .final_value(final_value),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .out_seq(out_seq), .res_full(res_full), .res_dropd(res_dropd),
        .drop_cnt(drop_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit op, input logic [31:0] v, input bit rdy);
        op_done     = op;
        final_value = v;
        out_ready   = rdy;
        @(posedge clk);
        #1;
    endtask

    // Reference model: a result list with occupancy, tag and drop accounting.
    initial begin
        forever begin
            bit pop_m;
            bit push_m;
            @(posedge clk);
            if (!rst_n) begin
                mcount  = 0;
                seq_m   = 0;
                drops_m = 0;
                dropd_m = 1'b0;
                exp_q.delete();
                started = 1'b1;
            end else begin
                pop_m   = (mcount > 0) && out_ready;
                push_m  = op_done && ((mcount < DEPTH) || pop_m);
                dropd_m = op_done && !push_m;
                if (pop_m) mcount--;
                if (push_m) begin
                    exp_q.push_back({final_value, 8'(seq_m)});
                    seq_m = (seq_m + 1) % 256;
                    mcount++;
                end
                if (dropd_m && drops_m < 65535) drops_m++;
            end
        end
    end

    // Monitor: compares flags each cycle and pops expectations on each handshake.
    initial begin
        forever begin
            logic [39:0] e;
            @(negedge clk);
            if (started) begin
                chk("out_valid", 64'(out_valid), 64'(mcount != 0));
                chk("res_full", 64'(res_full), 64'(mcount == DEPTH));
                chk("res_dropd", 64'(res_dropd), 64'(dropd_m));
                chk("drop_cnt", 64'(drop_cnt), 64'(drops_m));
                if (out_valid && out_ready && rst_n) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_output", 64'(1), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", 64'(out_data), 64'(e[39:8]));
                        chk("out_seq", 64'(out_seq), 64'(e[7:0]));
                    end
                end
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        op_done     = 1'b0;
        final_value = 32'h0;
        out_ready   = 1'b0;
        step(1'b1, 32'h1234, 1'b1);
        step(1'b1, 32'h5678, 1'b1);
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_out_seq", 64'(out_seq), 64'(0));
        chk("rst_res_full", 64'(res_full), 64'(0));
        chk("rst_res_dropd", 64'(res_dropd), 64'(0));
        chk("rst_drop_cnt", 64'(drop_cnt), 64'(0));
        rst_n = 1'b1;

        // Single result, then idle
        step(1'b1, 32'h0000_00A5, 1'b1);
        chk("single_valid", 64'(out_valid), 64'(1));
        chk("single_data", 64'(out_data), 64'(32'hA5));
        chk("single_seq", 64'(out_seq), 64'(0));
        step(1'b0, 32'h0, 1'b1);
        chk("single_gone", 64'(out_valid), 64'(0));

        // Fill with backpressure, then drain
        for (int i = 1; i <= 4; i++) step(1'b1, 32'(i), 1'b0);
        step(1'b0, 32'h0, 1'b0);
        chk("fill_full", 64'(res_full), 64'(1));
        chk("fill_head", 64'(out_data), 64'(32'h1));
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1);

        // Drop while full
        for (int i = 0; i < 4; i++) step(1'b1, $urandom, 1'b0);
        step(1'b1, 32'hDEAD, 1'b0);
        chk("drop_pulse", 64'(res_dropd), 64'(1));
        step(1'b0, 32'h0, 1'b0);
        chk("drop_pulse_end", 64'(res_dropd), 64'(0));
        chk("drop_cnt_one", 64'(drop_cnt), 64'(1));
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1);

        // Full with simultaneous pop: no drop
        for (int i = 0; i < 4; i++) step(1'b1, $urandom, 1'b0);
        step(1'b1, 32'h55, 1'b1);
        chk("fullpop_nodrop", 64'(res_dropd), 64'(0));
        chk("fullpop_full", 64'(res_full), 64'(1));
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1);

        // Stream 257 results to force the sequence tag through its wrap
        for (int i = 0; i < 257; i++) step(1'b1, $urandom, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1);

        // Drop counter saturation
        for (int i = 0; i < 4; i++) step(1'b1, $urandom, 1'b0);
        for (int i = 0; i < 65540; i++) step(1'b1, $urandom, 1'b0);
        chk("drop_sat", 64'(drop_cnt), 64'(16'hFFFF));
        step(1'b1, 32'hBEEF, 1'b0);
        chk("drop_sat_hold", 64'(drop_cnt), 64'(16'hFFFF));

        // Reset mid-stream with 3 entries held
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, $urandom, 1'b0);
        rst_n = 1'b0;
        step(1'b1, 32'h9999, 1'b1);
        rst_n = 1'b1;
        chk("midrst_valid", 64'(out_valid), 64'(0));
        chk("midrst_drop_cnt", 64'(drop_cnt), 64'(0));
        step(1'b1, 32'h77, 1'b0);
        chk("midrst_seq0", 64'(out_seq), 64'(0));
        chk("midrst_data", 64'(out_data), 64'(32'h77));
        step(1'b0, 32'h0, 1'b1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
